parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter: CAPACITY, 8, maximum cars parked; legal range 1..15.
REQ-002 Parameter: HOLD_CYCLES, 4, cycles the gate stays open after a car passes; legal range 1..255.
REQ-003 Parameter: TIMEOUT_CYCLES, 16, cycles an open gate waits for a car before closing; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 entry_req  input  1  level; car present at entrance sensor.
REQ-007 entry_auth  input  1  level; entrance password verified.
REQ-008 exit_req  input  1  level; car present at exit sensor.
REQ-009 car_passed  input  1  single-cycle pulse from gate beam sensor.
REQ-010 gate_open  output  1  registered barrier drive; 1 = raised.
REQ-011 entry_grant  output  1  registered; gate currently serving entrance.
REQ-012 exit_grant  output  1  registered; gate currently serving exit.
REQ-013 occupancy  output  4  registered count of parked cars.
REQ-014 full  output  1  registered; occupancy == CAPACITY.

Function
REQ-015 States: IDLE, ENTRY_OPEN, EXIT_OPEN, HOLD; state register encoding is implementation choice.
REQ-016 Entry eligible in IDLE: entry_req & entry_auth & ~full; exit eligible in IDLE: exit_req & (occupancy != 0).
REQ-017 IDLE, one eligible side: next state ENTRY_OPEN or EXIT_OPEN; grant and gate_open assert in the cycle after the sampling edge (1-cycle latency).
REQ-018 IDLE, both eligible: serve side not served last (round-robin flag); flag resets to "exit served last", so entry wins first contest.
REQ-019 ENTRY_OPEN/EXIT_OPEN: gate_open=1, matching grant=1, timer counts cycles from state entry.
REQ-020 car_passed in ENTRY_OPEN: occupancy +1 at that edge, next state HOLD; in EXIT_OPEN: occupancy -1, next state HOLD; round-robin flag updates to served side.
REQ-021 No car_passed within TIMEOUT_CYCLES cycles of open state: next state IDLE, gate_open=0, occupancy unchanged, round-robin flag unchanged.
REQ-022 HOLD: gate_open=1, both grants 0, stays HOLD_CYCLES cycles, then IDLE; car_passed ignored in HOLD and IDLE.
REQ-023 Occupancy saturates: never exceeds CAPACITY, never below 0, even on spurious car_passed.
REQ-024 full updates same edge as occupancy; entry_req while full never grants, gate stays closed.
REQ-025 entry_auth or entry_req dropping while ENTRY_OPEN does not close the gate; only car_passed or timeout leave the state.
REQ-026 entry_grant and exit_grant never both 1; grant=1 implies gate_open=1.

Reset
REQ-027 reset asserted: immediately state IDLE, gate_open=0, entry_grant=0, exit_grant=0, occupancy=0, full=0, timer=0, round-robin flag=exit.
REQ-028 reset mid-operation (gate open) closes the gate asynchronously and discards the occupancy count; first decision after release uses REQ-016 from clean state.

Configuration
REQ-029 Macro EXIT_PRIORITY_EN defined: when both eligible in IDLE, exit always wins; round-robin flag unused.
REQ-030 Macro EXIT_PRIORITY_EN undefined: round-robin per REQ-018; all other behaviour identical.

Verification
REQ-031 Reset, entry_req=1, entry_auth=1 one edge -> entry_grant=1, gate_open=1 next cycle; car_passed pulse -> occupancy=1; gate_open=1 for 4 more cycles then 0.
REQ-032 Entry granted, no car_passed -> gate_open drops after 16 cycles, occupancy unchanged at 0.
REQ-033 Fill to occupancy=8 -> full=1; further entry_req+entry_auth -> no grant, gate_open stays 0; one exit cycle -> occupancy=7, full=0.
REQ-034 occupancy=3, entry and exit eligible same cycle repeatedly -> grants alternate entry, exit, entry (macro undefined); exit every time with EXIT_PRIORITY_EN.
REQ-035 exit_req=1 with occupancy=0 -> no grant; spurious car_passed in IDLE -> occupancy stays 0.
REQ-036 reset pulse during EXIT_OPEN with occupancy=5 -> gate_open=0 and occupancy=0 without waiting for clk edge.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Purpose:
//   Arbitrates one barrier gate between a car park's entrance and exit lanes.
//   It tracks how many cars are parked, holds the barrier up briefly after a
//   car passes, and closes it again if an opened gate is not used in time.
//
// Parameters:
//   CAPACITY       maximum cars parked (1..15)
//   HOLD_CYCLES    cycles the gate stays up after a car passes (1..255)
//   TIMEOUT_CYCLES cycles an open gate waits for a car before closing (1..255)
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   reset        in   asynchronous, active-high reset
//   entry_req    in   level, car present at the entrance sensor
//   entry_auth   in   level, entrance password verified
//   exit_req     in   level, car present at the exit sensor
//   car_passed   in   single-cycle pulse from the gate beam sensor
//   gate_open    out  registered barrier drive, 1 = raised
//   entry_grant  out  registered, gate currently serving the entrance
//   exit_grant   out  registered, gate currently serving the exit
//   occupancy    out  registered count of parked cars (4 bits)
//   full         out  registered, occupancy == CAPACITY
//
// Configuration:
//   EXIT_PRIORITY_EN  when defined, a simultaneous entry/exit contest is always
//                     won by the exit. When undefined, contests alternate via a
//                     round-robin flag that starts as "exit served last".
// -----------------------------------------------------------------------------
module parking_gate_arbiter #(
  parameter int CAPACITY       = 8,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       entry_auth,
  input  logic       exit_req,
  input  logic       car_passed,
  output logic       gate_open,
  output logic       entry_grant,
  output logic       exit_grant,
  output logic [3:0] occupancy,
  output logic       full
);

  localparam logic [3:0] CAP_VAL      = 4'(CAPACITY);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN,
    HOLD
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] timer_reg, timer_next;
  logic [3:0] occupancy_next;
  logic       entry_eligible;
  logic       exit_eligible;
  logic       pick_entry;

`ifndef EXIT_PRIORITY_EN
  // 1 = entrance was the side served last; reset value means "exit served last"
  // so the entrance wins the first contest.
  logic       entry_last_reg, entry_last_next;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    occupancy_next  = occupancy;
    entry_eligible  = entry_req & entry_auth & ~full;
    exit_eligible   = exit_req & (occupancy != 4'd0);
`ifdef EXIT_PRIORITY_EN
    pick_entry      = 1'b0;
`else
    pick_entry      = ~entry_last_reg;
    entry_last_next = entry_last_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        timer_next = 8'd0;
        if (entry_eligible && exit_eligible) begin
          state_next = pick_entry ? ENTRY_OPEN : EXIT_OPEN;
        end else if (entry_eligible) begin
          state_next = ENTRY_OPEN;
        end else if (exit_eligible) begin
          state_next = EXIT_OPEN;
        end
      end

      ENTRY_OPEN: begin
        if (car_passed) begin
          // Saturate even though entry is never granted while full.
          if (occupancy != CAP_VAL) begin
            occupancy_next = occupancy + 4'd1;
          end
          state_next = HOLD;
          timer_next = 8'd0;
`ifndef EXIT_PRIORITY_EN
          entry_last_next = 1'b1;
`endif
        end else if (timer_reg == TIMEOUT_LAST) begin
          state_next = IDLE;
          timer_next = 8'd0;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end

      EXIT_OPEN: begin
        if (car_passed) begin
          if (occupancy != 4'd0) begin
            occupancy_next = occupancy - 4'd1;
          end
          state_next = HOLD;
          timer_next = 8'd0;
`ifndef EXIT_PRIORITY_EN
          entry_last_next = 1'b0;
`endif
        end else if (timer_reg == TIMEOUT_LAST) begin
          state_next = IDLE;
          timer_next = 8'd0;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end

      HOLD: begin
        // car_passed is deliberately ignored here.
        if (timer_reg == HOLD_LAST) begin
          state_next = IDLE;
          timer_next = 8'd0;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from the next state so
  // they line up with the state register without an extra cycle of latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= 8'd0;
      occupancy   <= 4'd0;
      full        <= 1'b0;
      gate_open   <= 1'b0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      occupancy   <= occupancy_next;
      full        <= (occupancy_next == CAP_VAL);
      gate_open   <= (state_next != IDLE);
      entry_grant <= (state_next == ENTRY_OPEN);
      exit_grant  <= (state_next == EXIT_OPEN);
    end
  end

`ifndef EXIT_PRIORITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_last_reg <= 1'b0;
    end else begin
      entry_last_reg <= entry_last_next;
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle the outputs
// are compared against a behavioural model that thinks in terms of "what the
// gate is doing" and "how many cycles it has left", counting down.
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

  localparam int CAP  = 8;
  localparam int HOLD = 4;
  localparam int TO   = 16;

  // Model modes
  localparam int M_CLOSED = 0;
  localparam int M_ENTRY  = 1;
  localparam int M_EXIT   = 2;
  localparam int M_HOLD   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0;
  logic       entry_auth = 1'b0;
  logic       exit_req = 1'b0;
  logic       car_passed = 1'b0;
  logic       gate_open;
  logic       entry_grant;
  logic       exit_grant;
  logic [3:0] occupancy;
  logic       full;

  int errors = 0;
  int checks = 0;

  int m_mode;
  int m_left;
  int m_occ;
  bit m_entry_last;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .CAPACITY      (CAP),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .entry_auth (entry_auth),
    .exit_req   (exit_req),
    .car_passed (car_passed),
    .gate_open  (gate_open),
    .entry_grant(entry_grant),
    .exit_grant (exit_grant),
    .occupancy  (occupancy),
    .full       (full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode       = M_CLOSED;
    m_left       = 0;
    m_occ        = 0;
    m_entry_last = 1'b0;
  endtask

  // One rising edge of the reference model.
  task automatic model_step(input bit er, input bit ea, input bit xr, input bit cp);
    bit e, x;
    int take;
    case (m_mode)
      M_CLOSED: begin
        e = er && ea && (m_occ < CAP);
        x = xr && (m_occ > 0);
        take = M_CLOSED;
        if (e && x) begin
`ifdef EXIT_PRIORITY_EN
          take = M_EXIT;
`else
          take = m_entry_last ? M_EXIT : M_ENTRY;
`endif
        end else if (e) begin
          take = M_ENTRY;
        end else if (x) begin
          take = M_EXIT;
        end
        if (take != M_CLOSED) begin
          m_mode = take;
          m_left = TO;
        end
      end
      M_ENTRY, M_EXIT: begin
        if (cp) begin
          if (m_mode == M_ENTRY && m_occ < CAP) m_occ++;
          if (m_mode == M_EXIT && m_occ > 0) m_occ--;
          m_entry_last = (m_mode == M_ENTRY);
          m_mode = M_HOLD;
          m_left = HOLD;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_CLOSED;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_CLOSED;
      end
    endcase
  endtask

  task automatic check_outputs();
    check("gate_open",   32'(gate_open),   32'(m_mode != M_CLOSED));
    check("entry_grant", 32'(entry_grant), 32'(m_mode == M_ENTRY));
    check("exit_grant",  32'(exit_grant),  32'(m_mode == M_EXIT));
    check("occupancy",   32'(occupancy),   32'(m_occ));
    check("full",        32'(full),        32'(m_occ == CAP));
  endtask

  task automatic cycle(input bit er, input bit ea, input bit xr, input bit cp);
    @(negedge clk);
    entry_req  = er;
    entry_auth = ea;
    exit_req   = xr;
    car_passed = cp;
    @(posedge clk);
    model_step(er, ea, xr, cp);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Grant one side, pass a car, sit out the hold time.
  task automatic serve(input bit entry_side);
    cycle(entry_side, entry_side, !entry_side, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (HOLD) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int p_entry, p_exit;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // First entry: 1-cycle grant latency, occupancy 1, hold then close.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("first_entry_grant", 32'(entry_grant), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("first_entry_occ", 32'(occupancy), 32'd1);
    repeat (HOLD) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_closed", 32'(gate_open), 32'd0);

    // Spurious pass in IDLE is ignored.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("spurious_idle_occ", 32'(occupancy), 32'd1);

    // Timeout with no car.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (TO) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_closed", 32'(gate_open), 32'd0);
    check("timeout_occ", 32'(occupancy), 32'd1);

    // Exit with empty park never grants.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("empty_exit_gate", 32'(gate_open), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("empty_spurious_occ", 32'(occupancy), 32'd0);

    // Fill to capacity, then entry is refused.
    for (int i = 0; i < CAP; i++) serve(1'b1);
    check("filled_occ", 32'(occupancy), 32'(CAP));
    check("filled_full", 32'(full), 32'd1);
    repeat (5) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("full_refuse", 32'(gate_open), 32'd0);
    end
    serve(1'b0);
    check("after_exit_occ", 32'(occupancy), 32'(CAP - 1));
    check("after_exit_full", 32'(full), 32'd0);

    // Contests at occupancy 3, flag left at "exit served last".
    do_reset();
    for (int i = 0; i < 4; i++) serve(1'b1);
    serve(1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef EXIT_PRIORITY_EN
      check("contest_exit", 32'(exit_grant), 32'd1);
`else
      check("contest_entry", 32'(entry_grant), 32'((k % 2) == 0));
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (HOLD) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset while the exit gate is open with five cars parked.
    do_reset();
    for (int i = 0; i < 5; i++) serve(1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_exit_grant", 32'(exit_grant), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_gate", 32'(gate_open), 32'd0);
    check("async_reset_occ", 32'(occupancy), 32'd0);
    check("async_reset_grant", 32'(exit_grant), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic in phases biased toward filling, mixing and emptying.
    for (int i = 0; i < 4000; i++) begin
      case (i / 1000)
        0:       begin p_entry = 80; p_exit = 10; end
        1:       begin p_entry = 50; p_exit = 50; end
        2:       begin p_entry = 20; p_exit = 80; end
        default: begin p_entry = 60; p_exit = 60; end
      endcase
      cycle($urandom_range(99) < p_entry,
            $urandom_range(99) < 85,
            $urandom_range(99) < p_exit,
            $urandom_range(99) < 25);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
